// File: rtl/regfile_writeback_queue_if.sv
// Enqueue-side handshake bundle for regfile_writeback_queue: one ALU and
// one memory write-request channel, each valid/ready with {dr, data}.
interface regfile_writeback_queue_if #(
  parameter int DW = 8,
  parameter int AW = 3
);

  logic          A_VALID;
  logic          A_READY;
  logic [AW-1:0] A_DR;
  logic [DW-1:0] A_DATA;

  logic          M_VALID;
  logic          M_READY;
  logic [AW-1:0] M_DR;
  logic [DW-1:0] M_DATA;

  // Request producers (ALU and memory result paths).
  modport master (
    output A_VALID, A_DR, A_DATA,
    output M_VALID, M_DR, M_DATA,
    input  A_READY, M_READY
  );

  // The write-back queue.
  modport slave (
    input  A_VALID, A_DR, A_DATA,
    input  M_VALID, M_DR, M_DATA,
    output A_READY, M_READY
  );

endinterface

// File: rtl/regfile_writeback_queue.sv
// Write-side front end of the register file: buffers ALU/memory write
// requests in an in-order circular FIFO, retires one per cycle onto
// LD/DR/D_OUT, and reports the youngest pending write for SA/SB.
module regfile_writeback_queue #(
  parameter int DW    = 8,
  parameter int AW    = 3,
  parameter int DEPTH = 4   // power of two, >= 2
) (
  input  logic                       CLK,
  input  logic                       RESET,
  regfile_writeback_queue_if.slave   enq,
  input  logic                       WB_STALL,
  output logic                       LD,
  output logic [AW-1:0]              DR,
  output logic [DW-1:0]              D_OUT,
  input  logic [AW-1:0]              SA,
  input  logic [AW-1:0]              SB,
  output logic                       PEND_A,
  output logic                       PEND_B,
  output logic [DW-1:0]              FWD_A,
  output logic [DW-1:0]              FWD_B,
  output logic [AW:0]                COUNT,
  output logic                       FULL,
  output logic                       EMPTY
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [AW-1:0] mem_dr   [DEPTH];
  logic [DW-1:0] mem_data [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count_q;

  logic          full;
  logic          empty;
  logic          a_fire;
  logic          m_fire;
  logic          enq_fire;
  logic          deq_fire;
  logic [AW-1:0] enq_dr;
  logic [DW-1:0] enq_data;

  // Occupancy is tracked by the counter alone; pointers never get compared.
  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);
  assign COUNT = count_q;
  assign FULL  = full;
  assign EMPTY = empty;

  // Readiness depends only on the current count, so a full queue refuses
  // a request even in a cycle where it also drains. ALU has fixed priority.
  assign enq.A_READY = !full;
  assign enq.M_READY = !full && !enq.A_VALID;

  assign a_fire   = enq.A_VALID && enq.A_READY;
  assign m_fire   = enq.M_VALID && enq.M_READY;
  assign enq_fire = a_fire || m_fire;
  assign enq_dr   = a_fire ? enq.A_DR   : enq.M_DR;
  assign enq_data = a_fire ? enq.A_DATA : enq.M_DATA;

  // Head entry drives the register-file write port; zeroed when empty.
  assign LD       = !empty && !WB_STALL;
  assign deq_fire = LD;
  assign DR       = empty ? '0 : mem_dr[rd_ptr];
  assign D_OUT    = empty ? '0 : mem_data[rd_ptr];

  // Pointer and occupancy bookkeeping; RESET wins over enqueue and drain.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (enq_fire) wr_ptr <= wr_ptr + PW'(1);
      if (deq_fire) rd_ptr <= rd_ptr + PW'(1);
      case ({enq_fire, deq_fire})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage written at the write pointer on an accepted request.
  // NOTE: the storage array is deliberately not reset; COUNT alone decides
  // which entries are valid, so stale contents are never observed.
  always_ff @(posedge CLK) begin
    if (enq_fire && !RESET) begin
      mem_dr[wr_ptr]   <= enq_dr;
      mem_data[wr_ptr] <= enq_data;
    end
  end

  // Pending/forward scan, oldest to youngest so the youngest match wins.
  // NOTE: every output of this block gets a default first, otherwise paths
  // that skip an assignment would infer latches.
  always_comb begin
    logic [PW-1:0] slot;
    PEND_A = 1'b0;
    PEND_B = 1'b0;
    FWD_A  = '0;
    FWD_B  = '0;
    slot   = rd_ptr;
    for (int i = 0; i < DEPTH; i++) begin
      slot = rd_ptr + PW'(i);
      if (CW'(i) < count_q) begin
        if (mem_dr[slot] == SA) begin
          PEND_A = 1'b1;
          FWD_A  = mem_data[slot];
        end
        if (mem_dr[slot] == SB) begin
          PEND_B = 1'b1;
          FWD_B  = mem_data[slot];
        end
      end
    end
  end

endmodule

// File: doc/regfile_writeback_queue.md
Name: regfile_writeback_queue

Overview:
- Write-side front end for the 8x8 register file. Accepts register-write requests from the ALU and memory result paths over valid/ready handshakes and buffers them in a small in-order FIFO.
- Retires one write per cycle onto the register file's LD/DR/D_in port.
- Reports whether a queued write is still pending for the two read-select addresses, and supplies the youngest pending value so the datapath can forward it or stall.

Parameters:
- DW, 8, data width; matches the register-file word.
- AW, 3, register address width (2^AW registers).
- DEPTH, 4, FIFO entries; must be a power of two and at least 2.

Ports:
- CLK  input  1  rising-edge clock.
- RESET  input  1  synchronous active-high reset.
- A_VALID  input  1  ALU write request valid.
- A_READY  output  1  ALU request accepted this cycle.
- A_DR  input  AW  ALU destination register.
- A_DATA  input  DW  ALU result.
- M_VALID  input  1  memory write request valid.
- M_READY  output  1  memory request accepted this cycle.
- M_DR  input  AW  memory destination register.
- M_DATA  input  DW  memory load data.
- WB_STALL  input  1  register-file write port unavailable; holds the head entry.
- LD  output  1  register-file write enable.
- DR  output  AW  register-file destination.
- D_OUT  output  DW  register-file write data.
- SA  input  AW  read-select A being issued.
- SB  input  AW  read-select B being issued.
- PEND_A  output  1  a queued write targets SA.
- PEND_B  output  1  a queued write targets SB.
- FWD_A  output  DW  data of the youngest queued entry targeting SA; 0 when PEND_A=0.
- FWD_B  output  DW  data of the youngest queued entry targeting SB; 0 when PEND_B=0.
- COUNT  output  AW+1  number of occupied entries (sized for DEPTH≤2^AW; widen if DEPTH is raised).
- FULL  output  1  COUNT==DEPTH.
- EMPTY  output  1  COUNT==0.

Behaviour:
- State: circular buffer of DEPTH entries {dr, data}; write pointer, read pointer, and COUNT register.
- Reset (synchronous, RESET=1 at a rising edge):
  - pointers=0, COUNT=0.
  - Stored entries are don't-care.
  - Post-reset outputs: LD=0, EMPTY=1, FULL=0, PEND_A=PEND_B=0, FWD_A=FWD_B=0, A_READY=1, M_READY=!A_VALID.
  - RESET overrides any simultaneous enqueue or drain, and discards queued writes mid-operation.
- Enqueue arbitration, at most one enqueue per cycle, ALU has fixed priority:
  - A_READY = !FULL.
  - M_READY = !FULL && !A_VALID.
  - A fire = A_VALID && A_READY; M fire = M_VALID && M_READY.
  - On a fire, the selected {dr, data} is written at the write pointer and the pointer increments modulo DEPTH.
- Ready is a function of the current COUNT only. A full queue refuses enqueue even in a cycle in which it drains.
- Drain:
  - LD = !EMPTY && !WB_STALL, combinational.
  - DR and D_OUT always show the head entry; they are 0 when EMPTY.
  - On a rising edge with LD=1, the register file captures the write and the read pointer increments modulo DEPTH.
- Latency: a request accepted at edge N appears on LD/DR/D_OUT in cycle N+1 when the queue was empty and unstalled. It retires at edge N+1.
- COUNT update:
  - +1 on enqueue only.
  - −1 on drain only.
  - Unchanged on simultaneous enqueue and drain, or on neither.
  - Never exceeds DEPTH and never underflows.
- Ordering: strictly FIFO. Multiple entries to the same DR retire oldest first, so the last write wins in the register file.
- Pending/forward logic (combinational over occupied entries, including the head being drained this cycle):
  - PEND_A = any occupied entry with dr==SA. FWD_A = data of the youngest such entry (closest to the write pointer). Same for SB with PEND_B/FWD_B.
  - A request being enqueued in the same cycle is not yet visible.
- Pointer wrap: pointers are AW-independent and log2(DEPTH) bits wide. Occupancy comes from COUNT, never from pointer comparison.
- WB_STALL held while full: the queue stays full, both READYs stay 0, and contents are preserved bit-exact.

Test Plan:
- Reset then idle -> EMPTY=1, LD=0, COUNT=0, A_READY=1, PEND_A=0, FWD_A=0.
- Single ALU write A_DR=3, A_DATA=0x5A at edge N -> cycle N+1: LD=1, DR=3, D_OUT=0x5A; EMPTY at N+2.
- A_VALID and M_VALID together (A: r1=0x11, M: r2=0x22) -> A accepted first, M_READY=0 that cycle; M accepted the next cycle; retire order r1 then r2.
- WB_STALL=1 and 5 ALU requests (r0..r4, 0x10..0x14) -> 4 accepted, FULL=1, A_READY=0 on the 5th. Release the stall -> 4 LD pulses in order; the 5th is accepted the cycle after FULL clears.
- Stall with queued writes r5=0xAA then r5=0xBB, SA=5, SB=6 -> PEND_A=1, FWD_A=0xBB, PEND_B=0, FWD_B=0.
- RESET asserted with 3 queued entries and A_VALID=1 -> next cycle COUNT=0, LD=0, no write issued; wrap-around check: 10 back-to-back writes through the DEPTH=4 queue retire intact and in order.
